// File: rtl/cic_pcm_conditioner.sv
// CIC output conditioner: EMA DC removal, left-shift gain with signed saturation,
// and a show-ahead FIFO that drops (and counts) samples when full.
module cic_pcm_conditioner #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    input  logic              dc_en,
    input  logic [3:0]        gain_shift,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    input  logic              clear_ovf
);

    localparam int ACC_W = IN_W + DC_SHIFT + 1;
    // Wide enough that a 15-bit left shift of any diff cannot wrap.
    localparam int SC_W  = ACC_W + 15;
    localparam logic signed [SC_W-1:0] MAX_V = SC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SC_W-1:0] MIN_V = SC_W'(-(2**(OUT_W-1)));
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] dc;
    logic signed [ACC_W-1:0] diff_c;
    logic signed [ACC_W-1:0] s1_diff;
    logic [3:0]              s1_gain;
    logic                    s1_valid;

    logic signed [SC_W-1:0]  scaled;
    logic [OUT_W-1:0]        sat_c;
    logic [OUT_W-1:0]        s2_data;
    logic                    s2_valid;

    logic [OUT_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic [ADDR_W:0]         count;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    drop;

    assign x_ext  = {{(ACC_W-IN_W){1'b0}}, in_data};
    assign dc     = acc >>> DC_SHIFT;
    assign diff_c = x_ext - dc;

    // Stage 1: DC estimate subtraction and accumulator update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            s1_diff  <= '0;
            s1_gain  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_gain <= gain_shift;
                if (dc_en) begin
                    s1_diff <= diff_c;
                    acc     <= acc + diff_c;
                end else begin
                    s1_diff <= x_ext;
                end
            end
        end
    end

    assign scaled = {{15{s1_diff[ACC_W-1]}}, s1_diff} <<< s1_gain;

    always_comb begin
        sat_c = scaled[OUT_W-1:0];
        if (scaled > MAX_V)
            sat_c = {1'b0, {(OUT_W-1){1'b1}}};
        else if (scaled < MIN_V)
            sat_c = {1'b1, {(OUT_W-1){1'b0}}};
    end

    // Stage 2: registered saturated sample feeding the FIFO write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= sat_c;
        end
    end

    // Full is judged on the pre-pop count, so a write into a full FIFO drops even if a pop happens.
    assign full = (count == FULL_CNT);
    assign push = s2_valid && !full;
    assign drop = s2_valid && full;
    assign pop  = (count != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf restarts the tally at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_cic_pcm_conditioner.sv
// Self-checking bench for cic_pcm_conditioner: vector table, scoreboard queue,
// and hand-written sequences for latency, overflow, concurrency and reset.
module tb_cic_pcm_conditioner;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        dc_en;
    logic [3:0]  gain_shift;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clear_ovf;

    cic_pcm_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .dc_en      (dc_en),
        .gain_shift (gain_shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .clear_ovf  (clear_ovf)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] d;
        logic [3:0]  gs;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [12];
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    longint      m_acc   = 0;

    bit dc_phase = 0;
    int dc_idx = 0, dc_prev = 0, dc_first = 0, dc_mono_bad = 0, dc_late_nz = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: EMA with alpha = 2^-8, shift, saturate to int16.
    function automatic logic [15:0] model(input logic [31:0] d, input logic dc, input logic [3:0] gs);
        longint x, diff, s;
        x    = longint'({32'd0, d});
        diff = dc ? x - (m_acc >>> 8) : x;
        if (dc)
            m_acc = m_acc + diff;
        s = diff <<< gs;
        if (s > 32767)
            return 16'h7FFF;
        else if (s < -32768)
            return 16'h8000;
        return s[15:0];
    endfunction

    // driver: one-cycle strobe; expected result pushed when stimulus is driven
    task automatic strobe(input logic [31:0] d, input logic dc, input logic [3:0] gs,
                          input bit do_push, input bit use_exp, input logic [15:0] e);
        logic [15:0] m;
        m          = model(d, dc, gs);
        in_data    = d;
        dc_en      = dc;
        gain_shift = gs;
        in_valid   = 1'b1;
        if (do_push)
            exp_q.push_back(use_exp ? e : m);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check({nm, "_drain_left"}, exp_q.size(), 0);
    endtask

    // scoreboard: compare head on every accepted output
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", longint'($signed(out_data)), -99999);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("sb_out_data", longint'($signed(out_data)), longint'($signed(e)));
            end
            if (dc_phase) begin
                if (dc_idx == 0)
                    dc_first = int'($signed(out_data));
                else if (int'($signed(out_data)) > dc_prev)
                    dc_mono_bad++;
                if (dc_idx >= 2000 && out_data != 16'd0)
                    dc_late_nz++;
                dc_prev = int'($signed(out_data));
                dc_idx++;
            end
        end
    end

    initial begin
        tbl[0]  = '{32'd100,        4'd0,  16'd100};
        tbl[1]  = '{32'd40000,      4'd0,  16'd32767};
        tbl[2]  = '{32'd3000,       4'd4,  16'd32767};
        tbl[3]  = '{32'd1000,       4'd4,  16'd16000};
        tbl[4]  = '{32'hFFFF_FFFF,  4'd15, 16'd32767};
        tbl[5]  = '{32'd0,          4'd0,  16'd0};
        tbl[6]  = '{32'd32767,      4'd0,  16'd32767};
        tbl[7]  = '{32'd32768,      4'd0,  16'd32767};
        tbl[8]  = '{32'd1,          4'd15, 16'd32767};
        tbl[9]  = '{32'd2047,       4'd4,  16'd32752};
        tbl[10] = '{32'd5,          4'd3,  16'd40};
        tbl[11] = '{32'd1,          4'd14, 16'd16384};

        // reset
        rst = 1'b0; in_data = '0; in_valid = 1'b0; dc_en = 1'b0; gain_shift = '0;
        out_ready = 1'b0; clear_ovf = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b1;
        tick();

        // bypass latency
        out_ready = 1'b1;
        strobe(32'd100, 1'b0, 4'd0, 1, 1, 16'd100);
        tick();
        check("lat_n1_valid", out_valid, 0);
        tick();
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_data", out_data, 100);
        tick();
        check("lat_n3_valid", out_valid, 0);

        // vector table, back-to-back strobes
        for (int i = 0; i < 12; i++)
            strobe(tbl[i].d, 1'b0, tbl[i].gs, 1, 1, tbl[i].exp);
        wait_drain("tbl", 40);

        // DC removal, back-to-back to stay within the cycle budget
        dc_phase = 1;
        for (int i = 0; i < 3000; i++)
            strobe(32'd64, 1'b1, 4'd0, 1, 0, 16'd0);
        wait_drain("dc", 40);
        dc_phase = 0;
        check("dc_first", dc_first, 64);
        check("dc_monotonic_violations", dc_mono_bad, 0);
        check("dc_late_nonzero", dc_late_nz, 0);
        check("dc_sample_count", dc_idx, 3000);

        // negative side: estimate above input
        strobe(32'd0, 1'b1, 4'd15, 1, 0, 16'd0);
        strobe(32'd0, 1'b1, 4'd0, 1, 0, 16'd0);
        strobe(32'd20, 1'b0, 4'd1, 1, 0, 16'd0);
        wait_drain("neg", 20);

        // overflow: 17 samples into 16 entries
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++)
            strobe(32'(i), 1'b0, 4'd0, i <= 16, 1, 16'(i));
        tick(); tick();
        check("ovf_fifo_count", fifo_count, 16);
        check("ovf_overflow", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 1);
        out_ready = 1'b1;
        wait_drain("ovf", 40);
        check("ovf_empty_valid", out_valid, 0);
        check("ovf_empty_count", fifo_count, 0);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_drop_cnt", drop_cnt, 0);

        // full + write + pop on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            strobe(32'(200 + i), 1'b0, 4'd0, 1, 1, 16'(200 + i));
        tick(); tick();
        check("conc_fill_count", fifo_count, 16);
        strobe(32'd999, 1'b0, 4'd0, 0, 0, 16'd0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("conc_fifo_count", fifo_count, 15);
        check("conc_drop_cnt", drop_cnt, 1);
        check("conc_overflow", overflow, 1);

        // drop coinciding with clear_ovf
        strobe(32'd300, 1'b0, 4'd0, 1, 1, 16'd300);
        tick(); tick();
        check("clrdrop_fill_count", fifo_count, 16);
        strobe(32'd301, 1'b0, 4'd0, 0, 0, 16'd0);
        tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clrdrop_drop_cnt", drop_cnt, 1);
        check("clrdrop_overflow", overflow, 1);
        check("clrdrop_fifo_count", fifo_count, 16);
        out_ready = 1'b1;
        wait_drain("clrdrop", 40);
        check("clrdrop_empty_valid", out_valid, 0);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            strobe(32'(500 + i), 1'b0, 4'd0, 1, 1, 16'(500 + i));
        tick(); tick();
        check("mid_fill_count", fifo_count, 5);
        strobe(32'd55, 1'b0, 4'd0, 0, 0, 16'd0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        exp_q.delete();
        m_acc = 0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        check("post_rst_count", fifo_count, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);
        out_ready = 1'b1;
        strobe(32'd7, 1'b0, 4'd0, 1, 1, 16'd7);
        wait_drain("post_rst", 10);
        check("post_rst_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_pcm_conditioner.md
Name: cic_pcm_conditioner

Overview:
- Directly downstream of the CIC decimator. Consumes its 32-bit unsigned pulse-count output, qualified by a one-cycle valid pulse.
- Removes the DC offset with a first-order exponential moving average, applies a programmable left-shift gain, and saturates to signed PCM.
- Buffers samples in a small show-ahead FIFO with a ready/valid output towards the correlation/UART stages.
- Reports overflow because the CIC side cannot be back-pressured.

Parameters:
- IN_W, 32, input sample width (unsigned).
- OUT_W, 16, output PCM width (signed two's complement).
- DC_SHIFT, 8, EMA time constant; alpha = 2^-DC_SHIFT.
- DEPTH, 16, FIFO depth in words; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous active-low reset; all state is cleared while low.
- in_data  in  IN_W  CIC output sample, unsigned.
- in_valid  in  1  one-cycle strobe qualifying in_data; back-to-back strobes are legal.
- dc_en  in  1  1 = subtract the DC estimate and update it; 0 = bypass and hold the estimate.
- gain_shift  in  4  left-shift amount, 0..15, sampled with each input sample.
- out_data  out  OUT_W  FIFO head sample, signed.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready at a posedge.
- fifo_count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky; a sample was dropped.
- drop_cnt  out  16  dropped-sample count; saturates at 0xFFFF.
- clear_ovf  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, fifo_count=0, overflow=0, drop_cnt=0.
  - DC accumulator=0, pipeline valid flags=0, FIFO pointers=0.
  - Takes effect immediately, mid-operation included; in-flight pipeline samples are discarded.
- Stage 1, the edge where in_valid=1:
  - x = {0, in_data} as an IN_W+1-bit signed value.
  - dc = acc >>> DC_SHIFT, where acc is signed with IN_W+DC_SHIFT+1 bits.
  - If dc_en: diff <= x - dc and acc <= acc + (x - dc).
  - If !dc_en: diff <= x and acc holds.
  - gain_shift is registered alongside diff.
- Stage 2, next edge:
  - scaled = diff <<< gain_shift, computed at full width with no wrap.
  - Saturate: scaled > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; scaled < -2^(OUT_W-1) gives -2^(OUT_W-1); otherwise truncate to OUT_W.
  - Result goes to the FIFO write port.
- Latency: a sample strobed at edge N is written at edge N+2 and is visible on out_data/out_valid after edge N+2 when the FIFO was empty. Throughput is one sample per clock.
- FIFO is show-ahead: out_data = mem[rd_ptr] and out_valid = (count != 0).
  - Pop occurs on out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
- Full handling: when a write is presented and count == DEPTH, evaluated before any same-cycle pop:
  - The sample is dropped and FIFO contents are unchanged.
  - overflow <= 1 and drop_cnt <= min(drop_cnt+1, 0xFFFF).
  - A same-cycle pop still proceeds.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Empty: out_ready is ignored and count never underflows.
- clear_ovf with a same-cycle drop: the drop wins, giving overflow=1 and drop_cnt=1. clear_ovf alone gives overflow=0 and drop_cnt=0.
- dc_en and gain_shift changes take effect for the next strobed sample only; samples already in the pipeline are unaffected.

Test Plan:
1. Bypass: dc_en=0, gain_shift=0, out_ready=1; strobe in_data=100 at edge N -> out_valid=1 with out_data=100 after edge N+2; out_valid=0 after edge N+3.
2. Saturation and gain: dc_en=0.
   - in_data=40000, gain_shift 0 -> 32767.
   - in_data=3000, gain_shift 4 -> 32767.
   - in_data=1000, gain_shift 4 -> 16000.
   - in_data=0xFFFFFFFF, gain_shift 15 -> 32767.
3. DC removal: dc_en=1, in_data=64 strobed every 50 clocks -> first output 64; outputs are monotonically non-increasing; output is 0 by sample 3000 and stays 0; acc holds at 16384 once settled.
4. Overflow: out_ready=0, strobe 17 distinct samples 1..17 back-to-back.
   - Response: fifo_count=16, overflow=1, drop_cnt=1.
   - Drain with out_ready=1 yields 1..16 in order, then out_valid=0.
   - clear_ovf pulse -> overflow=0, drop_cnt=0.
5. Concurrency: FIFO full; on the same edge a write arrives and out_ready=1 -> head popped, new sample dropped, fifo_count=15, drop_cnt increments.
6. Reset mid-operation: fifo_count=5 and a sample in stage 1; drive rst low between edges -> out_valid=0 and fifo_count=0 immediately; after release the first new sample of 7 emerges as 7 with dc_en=0.
